// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed hex driver for a DIGITS-wide common-anode 7-segment bank.
//   One digit is scanned per slot of SCAN_DIV clocks. The first GUARD clocks of
//   every slot keep all anodes off to stop ghosting. New values are loaded into a
//   pending buffer and copied to the display registers only at a frame boundary,
//   so a frame never shows a mix of old and new digits.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When it is defined, digit k>0 is blanked while nibbles k..DIGITS-1 are all zero.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_value      4*DIGITS hex nibbles, nibble k -> digit k (k=0 rightmost)
//   i_dp_in      decimal point request per digit, active-high
//   i_load       1-cycle strobe, captures i_value/i_dp_in into the pending buffer
//   o_upd_done   1-cycle pulse, pending buffer committed to the display
//   o_frame_tick 1-cycle pulse at the start of each frame (digit 0 slot)
//   o_seg        segments {a,b,c,d,e,f,g}, active-low
//   o_dp         decimal point, active-low
//   o_an         digit anodes, active-low, at most one low
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic                  i_load,
  output logic                  o_upd_done,
  output logic                  o_frame_tick,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp_val, r_pend_val;
  logic [DIGITS-1:0]   r_disp_dp, r_pend_dp;
  logic                r_pend_flag;
  logic                r_upd_done, r_frame_tick;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_slot_end, w_frame_end, w_guard;
  logic [3:0]          w_nib;
  logic                w_dp_sel, w_blank;
  logic [DIGITS-1:0]   w_an;

  // Active-high abcdefg pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; default: hex7 = 7'h47;
    endcase
  endfunction

  assign w_slot_end  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
  assign w_guard     = (r_div_cnt < DIV_W'(GUARD));

`ifdef LEADING_ZERO_BLANK_EN
  // w_upper_zero[k]: nibbles k..DIGITS-1 of the display are all zero.
  logic [DIGITS-1:0] w_upper_zero;
  assign w_upper_zero[DIGITS-1] = (r_disp_val[4*DIGITS-1 -: 4] == 4'h0);
  for (genvar k = 0; k < DIGITS-1; k++) begin : g_uz
    assign w_upper_zero[k] = (r_disp_val[4*k +: 4] == 4'h0) && w_upper_zero[k+1];
  end
`endif

  // Current-digit select, written as an explicit mux so non-power-of-two
  // DIGITS never indexes past the end of a vector.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    w_an     = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_disp_val[4*k +: 4];
        w_dp_sel = r_disp_dp[k];
        w_an[k]  = w_guard;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank  = (k != 0) && w_upper_zero[k];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_upd_done   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
    end else begin
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_idx     <= w_frame_end ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      r_frame_tick <= w_frame_end;
      r_upd_done   <= w_frame_end && r_pend_flag;

      // Commit uses the pending value from before this edge; a load on the
      // same edge is captured and left pending for the next frame.
      if (w_frame_end && r_pend_flag) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      if (i_load) begin
        r_pend_val  <= i_value;
        r_pend_dp   <= i_dp_in;
        r_pend_flag <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_flag <= 1'b0;
      end

      r_an  <= w_an;
      r_seg <= w_blank ? 7'h7F : ~hex7(w_nib);
      r_dp  <= ~w_dp_sel;
    end
  end

  assign o_upd_done   = r_upd_done;
  assign o_frame_tick = r_frame_tick;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_an         = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  localparam int FR = D * SD;

  logic           clk, rst_n;
  logic [4*D-1:0] value;
  logic [D-1:0]   dp_in;
  logic           load;
  logic           upd_done, frame_tick, dp;
  logic [6:0]     seg;
  logic [D-1:0]   an;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp_in(dp_in), .i_load(load),
    .o_upd_done(upd_done), .o_frame_tick(frame_tick), .o_seg(seg), .o_dp(dp), .o_an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset release plus the two value buffers.
  int           t;
  logic [15:0]  m_disp, m_pend;
  logic [3:0]   m_ddp, m_pdp;
  bit           m_pf;
  logic [6:0]   tbl [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pf = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_an"},  32'(an),         32'hF);
    chk({tag, "_seg"}, 32'(seg),        32'h7F);
    chk({tag, "_dp"},  32'(dp),         32'h1);
    chk({tag, "_ud"},  32'(upd_done),   32'h0);
    chk({tag, "_ft"},  32'(frame_tick), 32'h0);
  endtask

  // One clock: drive inputs, predict the registered outputs from the
  // position inside the frame, then compare just after the edge.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
    int pos, slot;
    logic [3:0] nib, e_an;
    logic [6:0] e_seg;
    bit e_ft, e_ud, e_dp;
    load = ld; value = v; dp_in = d;
    @(posedge clk);
    pos  = t % SD;
    slot = (t / SD) % D;
    nib  = m_disp[4*slot +: 4];
    e_an = (pos < G) ? 4'hF : ~(4'b0001 << slot);
    e_seg = ~tbl[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (m_disp >> (4*slot)) == 16'h0) e_seg = 7'h7F;
`endif
    e_dp = ~m_ddp[slot];
    e_ft = ((t + 1) % FR) == 0;
    e_ud = e_ft && m_pf;
    if (e_ud) begin m_disp = m_pend; m_ddp = m_pdp; end
    if (ld) begin m_pend = v; m_pdp = d; m_pf = 1; end
    else if (e_ft) m_pf = 0;
    t++;
    #1;
    chk("an",   32'(an),         32'(e_an));
    chk("seg",  32'(seg),        32'(e_seg));
    chk("dp",   32'(dp),         32'(e_dp));
    chk("ft",   32'(frame_tick), 32'(e_ft));
    chk("upd",  32'(upd_done),   32'(e_ud));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0);
  endtask

  // Advance until the next edge will be the one taken at frame phase p.
  task automatic to_phase(input int p);
    while ((t % FR) != p) step(0, 16'h0, 4'h0);
  endtask

  initial begin
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    rst_n = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_async");
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst_hold");
    rst_n = 1'b1;
    model_reset();

    // First frame: blank display scan, handshake load lands at cycle 5.
    idle(5);
    step(1, 16'h1234, 4'b0101);
    idle(10);
    chk("commit_disp", 32'(m_disp), 32'h1234);
    idle(FR);

    // All 16 hex digits, one load per frame.
    step(1, 16'hFEDC, 4'b1000); to_phase(0); idle(FR);
    step(1, 16'hBA98, 4'b0001); to_phase(0); idle(FR);
    step(1, 16'h7654, 4'b0110); to_phase(0); idle(FR);
    step(1, 16'h3210, 4'b1111); to_phase(0); idle(FR);

    // Collision: A loaded mid-frame, B loaded on the committing edge.
    to_phase(3);
    step(1, 16'hAAAA, 4'b0011);
    to_phase(FR - 1);
    step(1, 16'hBBBB, 4'b1100);
    chk("coll_a", 32'(m_disp), 32'hAAAA);
    to_phase(FR - 1);
    step(0, 16'h0, 4'h0);
    chk("coll_b", 32'(m_disp), 32'hBBBB);
    idle(FR);

    // Leading-zero patterns (blanked only in the optional build).
    step(1, 16'h0050, 4'b0000); to_phase(0); idle(FR);
    step(1, 16'h0000, 4'b0010); to_phase(0); idle(FR);

    // Repeated loads inside one frame: latest wins.
    step(1, 16'h1111, 4'h1); step(1, 16'h2222, 4'h2); step(1, 16'h3333, 4'h3);
    to_phase(0); idle(FR);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));

    // Reset in the middle of a slot with a load pending.
    to_phase(6);
    step(1, 16'h9876, 4'hF);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_mid");
    @(posedge clk);
    #1 chk_reset_outs("rst_mid_hold");
    rst_n = 1'b1;
    model_reset();
    idle(2 * FR);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
